frame_writer: RTL and testbench



---
 rtl/frame_writer.sv | 179 +++++++++++++++++
 tb/tb_frame_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// ============================================================================
// frame_writer : rectangle-fill / buffer-swap engine for a double-buffered SRAM frame buffer
// Optional macro FRAME_WRITER_CLIP_EN clamps oversize x1/y1 instead of rejecting the fill.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_writer #(
  parameter int   H_RES     = 800,
  parameter int   V_RES     = 600,
  parameter int   WR_CYCLES = 2,
  parameter logic VS_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_x1,
  input  logic [9:0]  cmd_y0,
  input  logic [9:0]  cmd_y1,
  input  logic [23:0] cmd_color,
  output logic        cmd_err,
  input  logic        vga_vsync,
  output logic        sram_wr_en,
  output logic [18:0] sram_wr_addr,
  output logic [31:0] sram_wr_data,
  output logic        wr_addr_offset,
  output logic        rd_addr_offset,
  output logic        busy
);

  localparam logic [10:0] C_H_RES     = 11'(H_RES);
  localparam logic [10:0] C_V_RES     = 11'(V_RES);
  localparam logic [18:0] C_STRIDE    = 19'(H_RES);
  localparam logic [3:0]  C_HOLD_LAST = 4'(WR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_WAIT_VS = 2'd2
  } state_t;

  state_t      state_q;
  logic        wr_en_q;
  logic [18:0] addr_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        wr_off_q;
  logic [9:0]  x_q, y_q, x0_q, x1_q, y1_q;
  logic [18:0] row_q;
  logic [3:0]  hold_q;

  logic        vs_meta_q, vs_sync_q, vs_act_prev_q;

  logic [9:0]  x1_d, y1_d;
  logic        fill_ok_d;
  logic [18:0] row0_d;
  logic        w_vs_act;
  logic        w_vs_edge;

`ifdef FRAME_WRITER_CLIP_EN
  localparam logic [9:0] C_H_MAX = 10'(H_RES - 1);
  localparam logic [9:0] C_V_MAX = 10'(V_RES - 1);

  assign x1_d      = ({1'b0, cmd_x1} >= C_H_RES) ? C_H_MAX : cmd_x1;
  assign y1_d      = ({1'b0, cmd_y1} >= C_V_RES) ? C_V_MAX : cmd_y1;
  assign fill_ok_d = ({1'b0, cmd_x0} < C_H_RES) && ({1'b0, cmd_y0} < C_V_RES) &&
                     (cmd_x0 <= x1_d) && (cmd_y0 <= y1_d);
`else
  assign x1_d      = cmd_x1;
  assign y1_d      = cmd_y1;
  assign fill_ok_d = (cmd_x0 <= cmd_x1) && (cmd_y0 <= cmd_y1) &&
                     ({1'b0, cmd_x1} < C_H_RES) && ({1'b0, cmd_y1} < C_V_RES);
`endif

  // Constant multiply only; folds into shift-adds at synthesis.
  assign row0_d = 19'(cmd_y0) * C_STRIDE;

  assign w_vs_act  = (vs_sync_q == VS_POL);
  assign w_vs_edge = w_vs_act & ~vs_act_prev_q;

  // Reset assumes vsync active so a swap right after reset never sees a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_meta_q     <= VS_POL;
      vs_sync_q     <= VS_POL;
      vs_act_prev_q <= 1'b1;
    end else begin
      vs_meta_q     <= vga_vsync;
      vs_sync_q     <= vs_meta_q;
      vs_act_prev_q <= w_vs_act;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      wr_off_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      row_q    <= '0;
      hold_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op) begin
              state_q <= S_WAIT_VS;
            end else if (fill_ok_d) begin
              state_q <= S_FILL;
              x0_q    <= cmd_x0;
              x1_q    <= x1_d;
              y1_q    <= y1_d;
              x_q     <= cmd_x0;
              y_q     <= cmd_y0;
              row_q   <= row0_d;
              addr_q  <= row0_d + 19'(cmd_x0);
              data_q  <= {8'h00, cmd_color};
              wr_en_q <= 1'b1;
              hold_q  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (hold_q != C_HOLD_LAST) begin
            hold_q <= hold_q + 4'd1;
          end else begin
            hold_q <= '0;
            if (x_q == x1_q) begin
              if (y_q == y1_q) begin
                wr_en_q <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                y_q    <= y_q + 10'd1;
                x_q    <= x0_q;
                row_q  <= row_q + C_STRIDE;
                addr_q <= row_q + C_STRIDE + 19'(x0_q);
              end
            end else begin
              x_q    <= x_q + 10'd1;
              addr_q <= addr_q + 19'd1;
            end
          end
        end
        S_WAIT_VS: begin
          if (w_vs_edge) begin
            wr_off_q <= ~wr_off_q;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign cmd_err        = err_q;
  assign sram_wr_en     = wr_en_q;
  assign sram_wr_addr   = addr_q;
  assign sram_wr_data   = data_q;
  assign wr_addr_offset = wr_off_q;
  assign rd_addr_offset = ~wr_off_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_writer.sv
// ============================================================================
// tb_frame_writer : scoreboard bench for frame_writer (fills, rejects, swap, reset abort)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_writer;

  localparam int WR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [9:0]  cmd_x0 = '0, cmd_x1 = '0, cmd_y0 = '0, cmd_y1 = '0;
  logic [23:0] cmd_color = '0;
  logic        cmd_err;
  logic        vga_vsync = 1'b0;
  logic        sram_wr_en;
  logic [18:0] sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic        wr_addr_offset;
  logic        rd_addr_offset;
  logic        busy;

  frame_writer #(.H_RES(800), .V_RES(600), .WR_CYCLES(WR), .VS_POL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_err(cmd_err), .vga_vsync(vga_vsync),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .wr_addr_offset(wr_addr_offset), .rd_addr_offset(rd_addr_offset), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          a;
    logic [31:0] d;
    logic        o;
  } wr_t;

  wr_t  expq[$];
  int   nchk = 0;
  int   nerr = 0;
  int   pix_cnt = 0;
  int   we_cycles = 0;
  int   err_cnt = 0;
  int   run = 0;
  logic exp_off = 1'b0;
  logic [18:0] cur_a;
  logic [31:0] cur_d;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: every pixel of the (possibly clipped) rectangle, row-major.
  task automatic model_fill(input int x0, input int y0, input int x1, input int y1,
                            input logic [23:0] col, output bit ok);
    int xe, ye;
    wr_t e;
    xe = x1;
    ye = y1;
`ifdef FRAME_WRITER_CLIP_EN
    if (xe > 799) xe = 799;
    if (ye > 599) ye = 599;
    ok = !(x0 > 799 || y0 > 599 || x0 > xe || y0 > ye);
`else
    ok = !(x0 > x1 || y0 > y1 || x1 > 799 || y1 > 599);
`endif
    if (ok)
      for (int y = y0; y <= ye; y++)
        for (int x = x0; x <= xe; x++) begin
          e.a = y * 800 + x;
          e.d = {8'h00, col};
          e.o = exp_off;
          expq.push_back(e);
        end
  endtask

  // Monitor: one pop per pixel, checks hold length and stability.
  always begin
    wr_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      run = 0;
    end else begin
      chk(rd_addr_offset == ~wr_addr_offset, "rd_is_not_wr", rd_addr_offset, ~wr_addr_offset);
      if (sram_wr_en) begin
        we_cycles++;
        if (run == 0 || run == WR) begin
          if (expq.size() == 0) begin
            chk(1'b0, "unexpected_write", sram_wr_addr, -1);
          end else begin
            e = expq.pop_front();
            chk(sram_wr_addr == 19'(e.a), "wr_addr", sram_wr_addr, e.a);
            chk(sram_wr_data == e.d, "wr_data", sram_wr_data, e.d);
            chk(wr_addr_offset == e.o, "wr_offset", wr_addr_offset, e.o);
          end
          cur_a = sram_wr_addr;
          cur_d = sram_wr_data;
          run = 1;
          pix_cnt++;
        end else begin
          chk(sram_wr_addr == cur_a && sram_wr_data == cur_d, "wr_hold_stable", sram_wr_addr, cur_a);
          run++;
        end
      end else if (run > 0) begin
        chk(run == WR, "wr_hold_len", run, WR);
        chk(!busy, "busy_after_last_write", busy, 0);
        run = 0;
      end
      if (cmd_err) err_cnt++;
    end
  end

  task automatic handshake(input bit op, input int x0, input int y0, input int x1,
                           input int y1, input logic [23:0] col);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x0    = 10'(x0);
    cmd_y0    = 10'(y0);
    cmd_x1    = 10'(x1);
    cmd_y1    = 10'(y1);
    cmd_color = col;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(cmd_ready, "ready_for_cmd", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    // Garbage outside the handshake must be ignored.
    cmd_op    = 1'($urandom);
    cmd_x0    = 10'($urandom);
    cmd_x1    = 10'($urandom);
    cmd_y0    = 10'($urandom);
    cmd_y1    = 10'($urandom);
    cmd_color = 24'($urandom);
  endtask

  task automatic do_fill(input int x0, input int y0, input int x1, input int y1,
                         input logic [23:0] col);
    bit ok;
    bit seen;
    int e0, n;
    e0 = err_cnt;
    model_fill(x0, y0, x1, y1, col, ok);
    handshake(1'b0, x0, y0, x1, y1, col);
    if (ok) begin
      seen = sram_wr_en;
      if (!seen) begin
        @(negedge clk);
        seen = sram_wr_en;
      end
      chk(seen, "first_write_latency", seen, 1);
    end else begin
      chk(cmd_ready, "ready_after_reject", cmd_ready, 1);
    end
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(!busy, "fill_completes", busy, 0);
    @(negedge clk);
    @(negedge clk);
    chk(err_cnt - e0 == (ok ? 0 : 1), "cmd_err_pulses", err_cnt - e0, ok ? 0 : 1);
    chk(expq.size() == 0, "pixels_outstanding", expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int p0, w0, n, x0, y0, x1, y1;
    bit ok;

    repeat (3) @(negedge clk);
    chk(sram_wr_en == 0, "rst_wr_en", sram_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);
    chk(sram_wr_en == 0, "rst_wr_en_after", sram_wr_en, 0);
    chk(sram_wr_addr == 0, "rst_addr", sram_wr_addr, 0);
    chk(sram_wr_data == 0, "rst_data", sram_wr_data, 0);
    chk(cmd_err == 0, "rst_err", cmd_err, 0);
    chk(wr_addr_offset == 0, "rst_wr_off", wr_addr_offset, 0);
    chk(rd_addr_offset == 1, "rst_rd_off", rd_addr_offset, 1);
    chk(cmd_ready == 1, "rst_ready", cmd_ready, 1);
    chk(busy == 0, "rst_busy", busy, 0);

    // Directed fill: 3x2 rectangle.
    p0 = pix_cnt;
    w0 = we_cycles;
    do_fill(10, 5, 12, 6, 24'h123456);
    chk(pix_cnt - p0 == 6, "t1_pixels", pix_cnt - p0, 6);
    chk(we_cycles - w0 == 12, "t1_we_cycles", we_cycles - w0, 12);
    chk(wr_addr_offset == 0 && rd_addr_offset == 1, "t1_offsets", wr_addr_offset, 0);

    // Bottom-right corner single pixel.
    w0 = we_cycles;
    do_fill(799, 599, 799, 599, 24'hABCDEF);
    chk(we_cycles - w0 == WR, "corner_we_cycles", we_cycles - w0, WR);

    do_fill(5, 0, 3, 0, 24'h000001);
    do_fill(795, 10, 900, 10, 24'h0F0F0F);
    do_fill(0, 598, 2, 700, 24'h777777);

    // Random fills, small rectangles near and past the edges.
    for (int i = 0; i < 40; i++) begin
      x0 = $urandom_range(0, 815);
      y0 = $urandom_range(0, 610);
      x1 = x0 + $urandom_range(0, 6);
      y1 = y0 + $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0: if (x0 > 0) x1 = x0 - 1;
        1: if (y0 > 0) y1 = y0 - 1;
        2: x1 = $urandom_range(800, 1023);
        default: ;
      endcase
      do_fill(x0, y0, x1, y1, 24'($urandom));
    end

    // Swap with vsync already active at entry.
    vga_vsync = 1'b1;
    repeat (10) @(negedge clk);
    handshake(1'b1, 0, 0, 0, 0, 24'h0);
    repeat (10) @(negedge clk);
    chk(wr_addr_offset == 0, "swap_no_early_toggle", wr_addr_offset, 0);
    chk(busy == 1, "swap_waiting_busy", busy, 1);
    vga_vsync = 1'b0;
    repeat (6) @(negedge clk);
    chk(wr_addr_offset == 0, "swap_no_toggle_on_fall", wr_addr_offset, 0);
    vga_vsync = 1'b1;
    n = 0;
    while (wr_addr_offset == 0 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk(wr_addr_offset == 1, "swap_wr_off", wr_addr_offset, 1);
    chk(rd_addr_offset == 0, "swap_rd_off", rd_addr_offset, 0);
    chk(cmd_ready == 1, "swap_back_idle", cmd_ready, 1);
    exp_off = 1'b1;
    do_fill(20, 30, 22, 31, 24'h55AA55);

    // Reset after exactly three pixels of a ten-pixel fill.
    model_fill(100, 100, 109, 100, 24'hC0FFEE, ok);
    p0 = pix_cnt;
    handshake(1'b0, 100, 100, 109, 100, 24'hC0FFEE);
    n = 0;
    while (!(pix_cnt - p0 == 3 && run == WR) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(pix_cnt - p0 == 3, "abort_point_reached", pix_cnt - p0, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    exp_off = 1'b0;
    chk(sram_wr_en == 0, "abort_wr_en", sram_wr_en, 0);
    chk(wr_addr_offset == 0, "abort_wr_off", wr_addr_offset, 0);
    chk(rd_addr_offset == 1, "abort_rd_off", rd_addr_offset, 1);
    chk(cmd_ready == 1, "abort_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk(pix_cnt - p0 == 3, "abort_no_more_writes", pix_cnt - p0, 3);

    do_fill(0, 0, 1, 0, 24'h010203);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
